serial_alu_v2: RTL and testbench

SERIAL_ALU_V2 -- requirements
Module: serial_alu_v2

---
 rtl/serial_alu_v2.sv | 153 +++++++++++++++
 tb/tb_serial_alu_v2.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_v2.sv
// rtl/serial_alu_v2.sv - bit-serial ALU (add/sub/logic/shift/mul) sequenced by an IDLE-RUN-DONE FSM
// Optional macro ALU_ASR_EN turns opcode 110 into an arithmetic right shift.
module serial_alu_v2 #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inp,
  input  logic [2:0]   opcode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] y,
  output logic [N-1:0] y_ext,
  output logic         ovf
);
  localparam int CW = $clog2(N + 1);
  localparam int SW = $clog2(N);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q;
  logic [2:0]    op_q;
  logic [N-1:0]  a_q, b_q, y_q, y_ext_q;
  logic [CW-1:0] cnt_q;
  logic          carry_q, ovf_q, busy_q, done_q, s_zero_q;

  logic [CW-1:0] cnt_load_d;
  logic [SW-1:0] s_amt_d;
  logic          b_bit_d;
  logic [1:0]    add_sum_d;
  logic [N:0]    mul_sum_d;
  logic [N-1:0]  shr_d;
  logic          last_d;

  always_comb begin
    s_amt_d = b[SW-1:0];
    case (opcode)
      OP_ADD, OP_SUB, OP_MUL: cnt_load_d = CW'(N);
      OP_SHL, OP_SHR:         cnt_load_d = (s_amt_d == '0) ? CW'(1) : CW'(s_amt_d);
      default:                cnt_load_d = CW'(1);
    endcase
    // Subtraction runs as a + ~b + 1: the +1 is the carry seeded at start.
    b_bit_d   = (op_q == OP_SUB) ? ~b_q[0] : b_q[0];
    add_sum_d = {1'b0, a_q[0]} + {1'b0, b_bit_d} + {1'b0, carry_q};
    mul_sum_d = {1'b0, y_ext_q} + (b_q[0] ? {1'b0, a_q} : {(N + 1){1'b0}});
`ifdef ALU_ASR_EN
    // The sign bit never changes under ASR, so a_q[N-1] remains the original a[N-1].
    shr_d = {a_q[N-1], a_q[N-1:1]};
`else
    shr_d = {1'b0, a_q[N-1:1]};
`endif
    last_d = (cnt_q == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      y_q      <= '0;
      y_ext_q  <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      s_zero_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (inp) begin
            op_q     <= opcode;
            a_q      <= a;
            b_q      <= b;
            y_q      <= '0;
            y_ext_q  <= '0;
            ovf_q    <= 1'b0;
            carry_q  <= (opcode == OP_SUB);
            s_zero_q <= (s_amt_d == '0);
            cnt_q    <= cnt_load_d;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
          case (op_q)
            OP_ADD, OP_SUB: begin
              a_q     <= a_q >> 1;
              b_q     <= b_q >> 1;
              carry_q <= add_sum_d[1];
              y_q     <= {add_sum_d[0], y_q[N-1:1]};
              if (last_d) ovf_q <= (op_q == OP_SUB) ? ~add_sum_d[1] : add_sum_d[1];
            end
            OP_AND: y_q <= a_q & b_q;
            OP_OR:  y_q <= a_q | b_q;
            OP_NOT: y_q <= ~a_q;
            OP_SHL: begin
              if (s_zero_q) begin
                y_q <= a_q;
              end else begin
                a_q <= {a_q[N-2:0], 1'b0};
                y_q <= {a_q[N-2:0], 1'b0};
              end
            end
            OP_SHR: begin
              if (s_zero_q) begin
                y_q <= a_q;
              end else begin
                a_q <= shr_d;
                y_q <= shr_d;
              end
            end
            OP_MUL: begin
              y_ext_q <= mul_sum_d[N:1];
              y_q     <= {mul_sum_d[0], y_q[N-1:1]};
              b_q     <= b_q >> 1;
            end
          endcase
          if (last_d) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign y     = y_q;
  assign y_ext = y_ext_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_alu_v2.sv
// tb/tb_serial_alu_v2.sv - serial_alu_v2 bench: behavioural model, per-cycle compare, directed vectors
// Honours ALU_ASR_EN for the expected shr fill.
module tb_serial_alu_v2;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inp = 1'b0;
  logic [2:0] opcode = '0;
  logic [3:0] a = '0, b = '0;
  logic       busy, done, ovf;
  logic [3:0] y, y_ext;

  logic       inp8 = 1'b0;
  logic [2:0] opcode8 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, ovf8;
  logic [7:0] y8, y_ext8;

  int checks = 0;
  int errors = 0;

`ifdef ALU_ASR_EN
  localparam logic [3:0] SHR_EXP = 4'b1101;
`else
  localparam logic [3:0] SHR_EXP = 4'b0101;
`endif

  serial_alu_v2 #(.N(4)) dut (
    .clk(clk), .rst(rst), .inp(inp), .opcode(opcode), .a(a), .b(b),
    .busy(busy), .done(done), .y(y), .y_ext(y_ext), .ovf(ovf)
  );

  serial_alu_v2 #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .inp(inp8), .opcode(opcode8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .y(y8), .y_ext(y_ext8), .ovf(ovf8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int run_len(input logic [2:0] op, input logic [3:0] bv);
    case (op)
      3'b000, 3'b001, 3'b111: return 4;
      3'b101, 3'b110:         return (bv[1:0] == 2'b00) ? 1 : int'(bv[1:0]);
      default:                return 1;
    endcase
  endfunction

  function automatic logic [3:0] shifted(input logic [2:0] op, input logic [3:0] av, input int k);
`ifdef ALU_ASR_EN
    logic signed [3:0] t;
    t = av;
`endif
    if (op == 3'b101) return 4'(av << k);
`ifdef ALU_ASR_EN
    return 4'(t >>> k);
`else
    return 4'(av >> k);
`endif
  endfunction

  task automatic final_result(input logic [2:0] op, input logic [3:0] av, input logic [3:0] bv,
                              output logic [3:0] ry, output logic [3:0] ryx, output logic rov);
    logic [4:0] s5;
    logic [7:0] p;
    ry = '0; ryx = '0; rov = 1'b0;
    case (op)
      3'b000: begin s5 = {1'b0, av} + {1'b0, bv}; ry = s5[3:0]; rov = s5[4]; end
      3'b001: begin ry = 4'(av - bv); rov = (av < bv); end
      3'b010: ry = av & bv;
      3'b011: ry = av | bv;
      3'b100: ry = ~av;
      3'b101, 3'b110: ry = shifted(op, av, (bv[1:0] == 2'b00) ? 0 : int'(bv[1:0]));
      default: begin p = {4'b0, av} * {4'b0, bv}; ry = p[3:0]; ryx = p[7:4]; end
    endcase
  endtask

  int         m_phase = 0, m_k = 0, m_len = 0;
  logic [2:0] m_op = '0;
  logic [3:0] m_a = '0, m_b = '0, m_y = '0, m_yext = '0;
  logic       m_ovf = 1'b0, m_busy = 1'b0, m_done = 1'b0;

  // Model: phase 0 idle, 1 operation running, 2 result pulse.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_phase = 0; m_busy = 1'b0; m_done = 1'b0;
      m_y = '0; m_yext = '0; m_ovf = 1'b0;
    end else if (m_phase == 0) begin
      if (inp) begin
        m_op = opcode; m_a = a; m_b = b; m_k = 0; m_len = run_len(opcode, b);
        m_y = '0; m_yext = '0; m_ovf = 1'b0; m_busy = 1'b1; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_k++;
      if (m_op inside {3'b101, 3'b110})
        m_y = shifted(m_op, m_a, (m_b[1:0] == 2'b00) ? 0 : m_k);
      if (m_k == m_len) begin
        final_result(m_op, m_a, m_b, m_y, m_yext, m_ovf);
        m_done = 1'b1; m_phase = 2;
      end
    end else begin
      m_done = 1'b0; m_busy = 1'b0; m_phase = 0;
    end
  end

  // Add/sub/mul partial words while running are internal; everything else is checked each cycle.
  initial forever begin
    @(negedge clk);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    if (m_phase != 1 || !(m_op inside {3'b000, 3'b001, 3'b111})) begin
      chk("y", y, m_y);
      chk("y_ext", y_ext, m_yext);
      chk("ovf", ovf, m_ovf);
    end
  end

  logic [3:0] ys [16];

  task automatic wait_done(output int lat);
    @(negedge clk);
    inp = 1'b0; opcode = 3'($urandom); a = 4'($urandom); b = 4'($urandom);
    lat = 0;
    while (lat < 64) begin
      @(negedge clk);
      lat++;
      ys[lat % 16] = y;
      inp = (lat == 1);
      if (done) break;
    end
    inp = 1'b0;
    chk("done_seen", done, 1'b1);
  endtask

  task automatic do_op(input logic [2:0] op, input logic [3:0] av, input logic [3:0] bv, output int lat);
    @(negedge clk);
    inp = 1'b1; opcode = op; a = av; b = bv;
    wait_done(lat);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [3:0] va, vb, ey, eyx;
    logic       eov;
    int         elat;
  } vec_t;

  initial begin
    vec_t vecs [11];
    int lat;
    vecs[0]  = '{3'b000, 4'b0101, 4'b1101, 4'b0010, 4'b0000, 1'b1, 4};
    vecs[1]  = '{3'b001, 4'b0101, 4'b1101, 4'b1000, 4'b0000, 1'b1, 4};
    vecs[2]  = '{3'b010, 4'b0101, 4'b1101, 4'b0101, 4'b0000, 1'b0, 1};
    vecs[3]  = '{3'b011, 4'b0101, 4'b1101, 4'b1101, 4'b0000, 1'b0, 1};
    vecs[4]  = '{3'b100, 4'b0101, 4'b1101, 4'b1010, 4'b0000, 1'b0, 1};
    vecs[5]  = '{3'b101, 4'b0101, 4'b0001, 4'b1010, 4'b0000, 1'b0, 1};
    vecs[6]  = '{3'b101, 4'b0101, 4'b0011, 4'b1000, 4'b0000, 1'b0, 3};
    vecs[7]  = '{3'b110, 4'b1010, 4'b0001, SHR_EXP, 4'b0000, 1'b0, 1};
    vecs[8]  = '{3'b111, 4'b0101, 4'b1101, 4'b0001, 4'b0100, 1'b0, 4};
    vecs[9]  = '{3'b101, 4'b0101, 4'b0100, 4'b0101, 4'b0000, 1'b0, 1};
    vecs[10] = '{3'b110, 4'b1001, 4'b1000, 4'b1001, 4'b0000, 1'b0, 1};

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_y", {y_ext, y}, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].op, vecs[i].va, vecs[i].vb, lat);
      chk($sformatf("vec%0d_y", i), y, vecs[i].ey);
      chk($sformatf("vec%0d_yext", i), y_ext, vecs[i].eyx);
      chk($sformatf("vec%0d_ovf", i), ovf, vecs[i].eov);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].elat);
      if (i == 6) begin
        chk("shl_seq1", ys[1], 4'b1010);
        chk("shl_seq2", ys[2], 4'b0100);
        chk("shl_seq3", ys[3], 4'b1000);
      end
    end

    @(negedge clk);
    inp8 = 1'b1; opcode8 = 3'b111; a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clk);
    inp8 = 1'b0; lat = 0;
    while (lat < 64 && !done8) begin
      @(negedge clk);
      lat++;
    end
    chk("n8_done", done8, 1'b1);
    chk("n8_prod", {y_ext8, y8}, 16'hFE01);
    chk("n8_ovf", ovf8, 1'b0);
    chk("n8_lat", lat, 8);

    // Reset lands on the second RUN cycle of a multiply; an add starts as reset drops.
    @(negedge clk);
    @(negedge clk);
    inp = 1'b1; opcode = 3'b111; a = 4'b0101; b = 4'b1101;
    @(negedge clk);
    inp = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_out", {ovf, y_ext, y}, 9'h000);
    rst = 1'b0; inp = 1'b1; opcode = 3'b000; a = 4'b0101; b = 4'b1101;
    wait_done(lat);
    chk("post_abort_y", y, 4'b0010);
    chk("post_abort_ovf", ovf, 1'b1);
    chk("post_abort_lat", lat, 4);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; inp = 1'b1; opcode = 3'b000;
    @(negedge clk);
    rst = 1'b0; inp = 1'b0;
    chk("rst_beats_inp", busy, 1'b0);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst    = ($urandom_range(0, 99) == 0);
      inp    = ($urandom_range(0, 2) == 0);
      opcode = 3'($urandom);
      a      = 4'($urandom);
      b      = 4'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; inp = 1'b0;
    repeat (8) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
